// File: rtl/sd_sector_buffer.sv
// rtl/sd_sector_buffer.sv - ping-pong 2x512 byte sector buffer between an SD SPI reader and a byte consumer
module sd_sector_buffer #(
  parameter logic [23:0] BASE_ADDRESS = 24'h000000,
  parameter logic [23:0] ADDR_STEP    = 24'd512,
  parameter logic [23:0] LAST_ADDRESS = 24'hFFFE00,
  parameter int          SKIP_BYTES   = 1
) (
  input  logic        DataClock,
  input  logic        Reset,
  input  logic [7:0]  InputData,
  input  logic        EnableDataRead,
  output logic [23:0] InputAddress,
  input  logic        RdReq,
  output logic [7:0]  RdData,
  output logic        RdValid,
  output logic        BufReady,
  output logic        Overrun,
  output logic        ShortSector,
  output logic [15:0] SectorCount
);

  typedef enum logic [2:0] {IDLE, SKIP, FILL, DROP, WAIT_LOW} writerState_t;

  localparam logic [7:0] SKIP_N = 8'(SKIP_BYTES);

  writerState_t state;
  logic [7:0]   bankRam [0:1023];
  logic [1:0]   full;
  logic         wrBank;
  logic         rdBank;
  logic [8:0]   wrPtr;
  logic [8:0]   rdPtr;
  logic [7:0]   skipCnt;
  logic         idleStore;
  logic         fillStore;
  logic         ramWrite;
  logic         sectorDone;
  logic         readAccept;
  logic         bankRelease;

  // Decode write strobes, sector completion and reader acceptance from current state
  always_comb begin
    idleStore   = (state == IDLE) && EnableDataRead && !full[wrBank] && (SKIP_BYTES == 0);
    fillStore   = (state == FILL) && EnableDataRead;
    ramWrite    = idleStore || fillStore;
    sectorDone  = fillStore && (wrPtr == 9'd511);
    readAccept  = RdReq && full[rdBank];
    bankRelease = readAccept && (rdPtr == 9'd511);
  end

  assign BufReady = full[rdBank];

  // Sector RAM write port; contents are never cleared, the full flags gate visibility
  always_ff @(posedge DataClock) begin
    if (ramWrite) begin
      bankRam[{wrBank, wrPtr}] <= InputData;
    end
  end

  // Writer FSM: skip the start token, fill the write bank, drop bursts when no bank is free
  always_ff @(posedge DataClock) begin
    if (Reset) begin
      state        <= IDLE;
      wrBank       <= 1'b0;
      wrPtr        <= 9'd0;
      skipCnt      <= 8'd0;
      InputAddress <= BASE_ADDRESS;
      SectorCount  <= 16'd0;
      Overrun      <= 1'b0;
      ShortSector  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EnableDataRead) begin
            if (full[wrBank]) begin
              state   <= DROP;
              Overrun <= 1'b1;
            end else if (SKIP_BYTES == 0) begin
              state <= FILL;
              wrPtr <= 9'd1;
            end else if (SKIP_BYTES == 1) begin
              state <= FILL;
            end else begin
              state   <= SKIP;
              skipCnt <= 8'd1;
            end
          end
        end
        SKIP: begin
          if (!EnableDataRead) begin
            state       <= IDLE;
            ShortSector <= 1'b1;
          end else begin
            skipCnt <= skipCnt + 8'd1;
            if (skipCnt + 8'd1 == SKIP_N) begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (!EnableDataRead) begin
            state       <= IDLE;
            wrPtr       <= 9'd0;
            ShortSector <= 1'b1;
          end else if (wrPtr == 9'd511) begin
            state       <= WAIT_LOW;
            wrPtr       <= 9'd0;
            wrBank      <= ~wrBank;
            SectorCount <= SectorCount + 16'd1;
            if (InputAddress >= LAST_ADDRESS) begin
              InputAddress <= BASE_ADDRESS;
            end else begin
              InputAddress <= InputAddress + ADDR_STEP;
            end
          end else begin
            wrPtr <= wrPtr + 9'd1;
          end
        end
        DROP, WAIT_LOW: begin
          if (!EnableDataRead) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank full flags: writer marks its bank on completion, reader frees its bank after the last byte
  always_ff @(posedge DataClock) begin
    if (Reset) begin
      full <= 2'b00;
    end else begin
      if (sectorDone) begin
        full[wrBank] <= 1'b1;
      end
      if (bankRelease) begin
        full[rdBank] <= 1'b0;
      end
    end
  end

  // Reader: one-cycle read latency, RdData holds between accepted requests
  always_ff @(posedge DataClock) begin
    if (Reset) begin
      rdBank  <= 1'b0;
      rdPtr   <= 9'd0;
      RdData  <= 8'd0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= readAccept;
      if (readAccept) begin
        RdData <= bankRam[{rdBank, rdPtr}];
        if (rdPtr == 9'd511) begin
          rdPtr  <= 9'd0;
          rdBank <= ~rdBank;
        end else begin
          rdPtr <= rdPtr + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb/tb_sd_sector_buffer.sv - self-checking bench for sd_sector_buffer against a sector-queue model
module tb_sd_sector_buffer;

  localparam logic [23:0] BASE = 24'h000000;
  localparam logic [23:0] STEP = 24'd512;
  localparam logic [23:0] LAST = 24'h000400;
  localparam int          SKIP = 1;

  logic        DataClock;
  logic        Reset;
  logic [7:0]  InputData;
  logic        EnableDataRead;
  logic [23:0] InputAddress;
  logic        RdReq;
  logic [7:0]  RdData;
  logic        RdValid;
  logic        BufReady;
  logic        Overrun;
  logic        ShortSector;
  logic [15:0] SectorCount;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 0;

  sd_sector_buffer #(
    .BASE_ADDRESS(BASE),
    .ADDR_STEP(STEP),
    .LAST_ADDRESS(LAST),
    .SKIP_BYTES(SKIP)
  ) dut (
    .DataClock(DataClock),
    .Reset(Reset),
    .InputData(InputData),
    .EnableDataRead(EnableDataRead),
    .InputAddress(InputAddress),
    .RdReq(RdReq),
    .RdData(RdData),
    .RdValid(RdValid),
    .BufReady(BufReady),
    .Overrun(Overrun),
    .ShortSector(ShortSector),
    .SectorCount(SectorCount)
  );

  initial begin
    DataClock = 0;
    forever #5 DataClock = ~DataClock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dataByte(input int k, input int seed);
    return 8'((k + seed * 37) & 255);
  endfunction

  // Model: completed sectors are a byte queue of at most two sectors; reads pop from the front
  logic [7:0]  mStore[$];
  logic [7:0]  mFill[$];
  logic [23:0] mAddr;
  logic [15:0] mCount;
  logic        mOverrun;
  logic        mShort;
  logic        mValid;
  logic [7:0]  mData;
  bit          mInBurst;
  bit          mAccept;
  int          mBurstPos;
  int          mBanksUsed;

  always @(posedge DataClock) begin
    if (Reset) begin
      mStore.delete();
      mFill.delete();
      mAddr    = BASE;
      mCount   = 0;
      mOverrun = 0;
      mShort   = 0;
      mValid   = 0;
      mData    = 0;
      mInBurst = 0;
      mAccept  = 0;
      mBurstPos = 0;
    end else begin
      mBanksUsed = (mStore.size() + 511) / 512;
      mValid = 0;
      if (RdReq && mStore.size() > 0) begin
        mData  = mStore.pop_front();
        mValid = 1;
      end
      if (EnableDataRead) begin
        if (!mInBurst) begin
          mInBurst  = 1;
          mBurstPos = 0;
          mFill.delete();
          mAccept = (mBanksUsed < 2);
          if (!mAccept) mOverrun = 1;
        end
        if (mAccept && mBurstPos >= SKIP && mFill.size() < 512) begin
          mFill.push_back(InputData);
          if (mFill.size() == 512) begin
            for (int i = 0; i < 512; i++) mStore.push_back(mFill[i]);
            mCount = mCount + 16'd1;
            if (mAddr >= LAST) mAddr = BASE;
            else mAddr = mAddr + STEP;
          end
        end
        mBurstPos++;
      end else begin
        if (mInBurst && mAccept && mFill.size() < 512) mShort = 1;
        mInBurst = 0;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge DataClock) begin
    if (checkEn) begin
      check("RdValid", 32'(RdValid), 32'(mValid));
      check("RdData", 32'(RdData), 32'(mData));
      check("BufReady", 32'(BufReady), 32'(mStore.size() > 0));
      check("InputAddress", 32'(InputAddress), 32'(mAddr));
      check("SectorCount", 32'(SectorCount), 32'(mCount));
      check("Overrun", 32'(Overrun), 32'(mOverrun));
      check("ShortSector", 32'(ShortSector), 32'(mShort));
    end
  end

  task automatic cyc();
    @(posedge DataClock);
    #1;
  endtask

  task automatic doReset();
    Reset = 1;
    EnableDataRead = 0;
    RdReq = 0;
    InputData = 0;
    cyc();
    Reset = 0;
  endtask

  task automatic burst(input int n, input int seed);
    EnableDataRead = 1;
    InputData = 8'hFE;
    cyc();
    for (int k = 0; k < n; k++) begin
      InputData = dataByte(k, seed);
      cyc();
    end
    EnableDataRead = 0;
    InputData = 0;
    cyc();
    cyc();
  endtask

  task automatic readN(input int n);
    RdReq = 1;
    repeat (n) cyc();
    RdReq = 0;
    cyc();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_addr"}, 32'(InputAddress), 32'h000000);
    check({tag, "_count"}, 32'(SectorCount), 32'd0);
    check({tag, "_bufready"}, 32'(BufReady), 32'd0);
    check({tag, "_rdvalid"}, 32'(RdValid), 32'd0);
    check({tag, "_rddata"}, 32'(RdData), 32'd0);
    check({tag, "_overrun"}, 32'(Overrun), 32'd0);
    check({tag, "_short"}, 32'(ShortSector), 32'd0);
  endtask

  initial begin
    Reset = 1;
    EnableDataRead = 0;
    RdReq = 0;
    InputData = 0;
    cyc();
    checkEn = 1;
    doReset();
    checkResetValues("reset");

    // Single sector, read back with literal data expectations
    burst(512, 0);
    check("s1_bufready", 32'(BufReady), 32'd1);
    check("s1_addr", 32'(InputAddress), 32'h000200);
    check("s1_count", 32'(SectorCount), 32'd1);
    RdReq = 1;
    for (int k = 0; k < 512; k++) begin
      cyc();
      check("s1_rdvalid", 32'(RdValid), 32'd1);
      check("s1_rddata", 32'(RdData), 32'(k % 256));
    end
    RdReq = 0;
    cyc();
    check("s1_rdvalid_end", 32'(RdValid), 32'd0);
    check("s1_rddata_hold", 32'(RdData), 32'd255);
    check("s1_bufready_end", 32'(BufReady), 32'd0);

    // Three sectors without reading: third is dropped
    doReset();
    burst(512, 1);
    burst(512, 2);
    burst(512, 3);
    check("ovr_flag", 32'(Overrun), 32'd1);
    check("ovr_addr", 32'(InputAddress), 32'h000400);
    check("ovr_count", 32'(SectorCount), 32'd2);
    readN(1024);
    check("ovr_bufready_end", 32'(BufReady), 32'd0);

    // Short burst, requests on empty buffer, then a full sector
    doReset();
    burst(100, 4);
    check("short_flag", 32'(ShortSector), 32'd1);
    check("short_bufready", 32'(BufReady), 32'd0);
    check("short_addr", 32'(InputAddress), 32'h000000);
    RdReq = 1;
    cyc();
    check("empty_rdvalid", 32'(RdValid), 32'd0);
    RdReq = 0;
    burst(512, 5);
    check("short_next_count", 32'(SectorCount), 32'd1);
    check("short_next_addr", 32'(InputAddress), 32'h000200);
    readN(512);

    // Address wrap at LAST
    doReset();
    burst(512, 6);
    check("wrap_addr1", 32'(InputAddress), 32'h000200);
    readN(512);
    burst(512, 7);
    check("wrap_addr2", 32'(InputAddress), 32'h000400);
    readN(512);
    burst(512, 8);
    check("wrap_addr3", 32'(InputAddress), 32'h000000);
    readN(512);

    // Reader releases bank 0 on the same edge the writer completes bank 1
    doReset();
    burst(512, 9);
    for (int c = 0; c <= 512; c++) begin
      EnableDataRead = 1;
      InputData = (c == 0) ? 8'hFE : dataByte(c - 1, 10);
      RdReq = (c >= 1);
      cyc();
    end
    EnableDataRead = 0;
    RdReq = 0;
    InputData = 0;
    cyc();
    check("same_bufready", 32'(BufReady), 32'd1);
    check("same_count", 32'(SectorCount), 32'd2);
    check("same_overrun", 32'(Overrun), 32'd0);
    RdReq = 1;
    cyc();
    check("same_first", 32'(RdData), 32'(dataByte(0, 10)));
    RdReq = 0;
    readN(511);
    check("same_bufready_end", 32'(BufReady), 32'd0);

    // Reset in the middle of a burst
    doReset();
    EnableDataRead = 1;
    InputData = 8'hFE;
    cyc();
    for (int k = 0; k < 300; k++) begin
      InputData = dataByte(k, 11);
      cyc();
    end
    doReset();
    checkResetValues("midreset");
    burst(512, 12);
    check("midreset_count", 32'(SectorCount), 32'd1);
    check("midreset_addr", 32'(InputAddress), 32'h000200);
    readN(512);

    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
